// File: rtl/axis_pipe_slice.sv
// AXI4-Stream pipeline of STAGES cascaded 2-entry skid slices (STAGES=0 is a plain wire-through).
// Optional AXIS_PIPE_SLICE_STAT_EN adds beat_cnt / pkt_cnt / stall_cnt observation counters.
module axis_pipe_slice #(
  parameter int DSIZE  = 32,
  parameter int KSIZE  = DSIZE / 8,
  parameter int USIZE  = 1,
  parameter int STAGES = 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [DSIZE-1:0] s_axis_tdata,
  input  logic [KSIZE-1:0] s_axis_tkeep,
  input  logic [USIZE-1:0] s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [DSIZE-1:0] m_axis_tdata,
  output logic [KSIZE-1:0] m_axis_tkeep,
  output logic [USIZE-1:0] m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
`ifdef AXIS_PIPE_SLICE_STAT_EN
  ,
  output logic [31:0]      beat_cnt,
  output logic [31:0]      pkt_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int PW = DSIZE + KSIZE + USIZE + 1;

  if (STAGES > 8 || (DSIZE % 8) != 0) begin : g_bad_cfg
    $error("axis_pipe_slice: STAGES must be 0..8 and DSIZE a multiple of 8");
  end

  // Index i is the link feeding slice i; index STAGES is the m_axis side.
  logic [STAGES:0]         vld_w;
  logic [STAGES:0]         rdy_w;
  logic [STAGES:0][PW-1:0] pl_w;

  assign vld_w[0]      = s_axis_tvalid;
  assign pl_w[0]       = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  assign s_axis_tready = rdy_w[0];
  assign rdy_w[STAGES] = m_axis_tready;
  assign m_axis_tvalid = vld_w[STAGES];
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = pl_w[STAGES];

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = aclk ^ areset;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [PW-1:0] main_pl_q, main_pl_d;
    logic [PW-1:0] skid_pl_q, skid_pl_d;
    logic          rdy_q;
    logic          in_xfer, out_xfer;

    assign in_xfer  = vld_w[i] && rdy_q;
    assign out_xfer = main_vld_q && rdy_w[i+1];

    always_comb begin
      // NOTE: next-state defaults to current state so no path leaves a latch.
      main_vld_d = main_vld_q;
      main_pl_d  = main_pl_q;
      skid_vld_d = skid_vld_q;
      skid_pl_d  = skid_pl_q;
      if (!main_vld_q) begin
        if (in_xfer) begin
          main_vld_d = 1'b1;
          main_pl_d  = pl_w[i];
        end
      end else if (out_xfer) begin
        // A full skid means rdy_q is low, so no incoming beat competes here.
        if (skid_vld_q) begin
          main_pl_d  = skid_pl_q;
          skid_vld_d = 1'b0;
        end else if (in_xfer) begin
          main_pl_d  = pl_w[i];
        end else begin
          main_vld_d = 1'b0;
        end
      end else if (in_xfer) begin
        skid_vld_d = 1'b1;
        skid_pl_d  = pl_w[i];
      end
    end

    // NOTE: state flops use non-blocking assignment so every slice samples pre-edge values.
    always_ff @(posedge aclk) begin
      if (areset) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
        rdy_q      <= 1'b0;
      end else begin
        main_vld_q <= main_vld_d;
        skid_vld_q <= skid_vld_d;
        rdy_q      <= !skid_vld_d;
      end
    end

    // NOTE: payload storage is not reset; the valid bits alone define occupancy.
    always_ff @(posedge aclk) begin
      main_pl_q <= main_pl_d;
      skid_pl_q <= skid_pl_d;
    end

    assign rdy_w[i]    = rdy_q;
    assign vld_w[i+1]  = main_vld_q;
    assign pl_w[i+1]   = main_pl_q;
  end

`ifdef AXIS_PIPE_SLICE_STAT_EN
  logic [31:0] beat_cnt_q, pkt_cnt_q, stall_cnt_q;
  logic        m_xfer;

  assign m_xfer = vld_w[STAGES] && rdy_w[STAGES];

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (m_xfer)                         beat_cnt_q  <= beat_cnt_q + 32'd1;
      if (m_xfer && m_axis_tlast)         pkt_cnt_q   <= pkt_cnt_q + 32'd1;
      if (vld_w[STAGES] && !rdy_w[STAGES]) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pipe_slice.sv
// Scoreboarded bench for axis_pipe_slice: four instances (STAGES 2, 3/64-bit, 1, 0).
// Drivers push expected beats into FIFO models; negedge monitors pop and compare.
module tb_axis_pipe_slice;

  localparam int PA = 32 + 4 + 1 + 1;
  localparam int PB = 64 + 8 + 1 + 1;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Instance A: STAGES=2
  logic rst_a, a_s_user, a_s_last, a_s_valid, a_s_ready, a_m_user, a_m_last, a_m_valid, a_m_ready;
  logic [31:0] a_s_data, a_m_data;
  logic [3:0]  a_s_keep, a_m_keep;
  // Instance B: STAGES=3, DSIZE=64
  logic rst_b, b_s_user, b_s_last, b_s_valid, b_s_ready, b_m_user, b_m_last, b_m_valid, b_m_ready;
  logic [63:0] b_s_data, b_m_data;
  logic [7:0]  b_s_keep, b_m_keep;
  // Instance C: STAGES=1
  logic rst_c, c_s_user, c_s_last, c_s_valid, c_s_ready, c_m_user, c_m_last, c_m_valid, c_m_ready;
  logic [31:0] c_s_data, c_m_data;
  logic [3:0]  c_s_keep, c_m_keep;
  // Instance D: STAGES=0
  logic rst_d, d_s_user, d_s_last, d_s_valid, d_s_ready, d_m_user, d_m_last, d_m_valid, d_m_ready;
  logic [31:0] d_s_data, d_m_data;
  logic [3:0]  d_s_keep, d_m_keep;

`ifdef AXIS_PIPE_SLICE_STAT_EN
  logic [31:0] st_beat [4];
  logic [31:0] st_pkt  [4];
  logic [31:0] st_stall[4];
`endif

  axis_pipe_slice #(.DSIZE(32), .STAGES(2)) dut_a (
    .aclk(clk), .areset(rst_a),
    .s_axis_tdata(a_s_data), .s_axis_tkeep(a_s_keep), .s_axis_tuser(a_s_user),
    .s_axis_tlast(a_s_last), .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready),
    .m_axis_tdata(a_m_data), .m_axis_tkeep(a_m_keep), .m_axis_tuser(a_m_user),
    .m_axis_tlast(a_m_last), .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready)
`ifdef AXIS_PIPE_SLICE_STAT_EN
    , .beat_cnt(st_beat[0]), .pkt_cnt(st_pkt[0]), .stall_cnt(st_stall[0])
`endif
  );

  axis_pipe_slice #(.DSIZE(64), .STAGES(3)) dut_b (
    .aclk(clk), .areset(rst_b),
    .s_axis_tdata(b_s_data), .s_axis_tkeep(b_s_keep), .s_axis_tuser(b_s_user),
    .s_axis_tlast(b_s_last), .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready),
    .m_axis_tdata(b_m_data), .m_axis_tkeep(b_m_keep), .m_axis_tuser(b_m_user),
    .m_axis_tlast(b_m_last), .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready)
`ifdef AXIS_PIPE_SLICE_STAT_EN
    , .beat_cnt(st_beat[1]), .pkt_cnt(st_pkt[1]), .stall_cnt(st_stall[1])
`endif
  );

  axis_pipe_slice #(.DSIZE(32), .STAGES(1)) dut_c (
    .aclk(clk), .areset(rst_c),
    .s_axis_tdata(c_s_data), .s_axis_tkeep(c_s_keep), .s_axis_tuser(c_s_user),
    .s_axis_tlast(c_s_last), .s_axis_tvalid(c_s_valid), .s_axis_tready(c_s_ready),
    .m_axis_tdata(c_m_data), .m_axis_tkeep(c_m_keep), .m_axis_tuser(c_m_user),
    .m_axis_tlast(c_m_last), .m_axis_tvalid(c_m_valid), .m_axis_tready(c_m_ready)
`ifdef AXIS_PIPE_SLICE_STAT_EN
    , .beat_cnt(st_beat[2]), .pkt_cnt(st_pkt[2]), .stall_cnt(st_stall[2])
`endif
  );

  axis_pipe_slice #(.DSIZE(32), .STAGES(0)) dut_d (
    .aclk(clk), .areset(rst_d),
    .s_axis_tdata(d_s_data), .s_axis_tkeep(d_s_keep), .s_axis_tuser(d_s_user),
    .s_axis_tlast(d_s_last), .s_axis_tvalid(d_s_valid), .s_axis_tready(d_s_ready),
    .m_axis_tdata(d_m_data), .m_axis_tkeep(d_m_keep), .m_axis_tuser(d_m_user),
    .m_axis_tlast(d_m_last), .m_axis_tvalid(d_m_valid), .m_axis_tready(d_m_ready)
`ifdef AXIS_PIPE_SLICE_STAT_EN
    , .beat_cnt(st_beat[3]), .pkt_cnt(st_pkt[3]), .stall_cnt(st_stall[3])
`endif
  );

  // Reference model: each link is an in-order FIFO of accepted beats.
  logic [PA-1:0] qa[$];
  logic [PB-1:0] qb[$];
  logic [PA-1:0] qc[$];

  wire [PA-1:0] pa_now = {a_m_data, a_m_keep, a_m_user, a_m_last};
  wire [PB-1:0] pb_now = {b_m_data, b_m_keep, b_m_user, b_m_last};
  wire [PA-1:0] pc_now = {c_m_data, c_m_keep, c_m_user, c_m_last};

  int a_in_cyc, a_first_out, a_last_out, a_out_cnt;
  logic [PA-1:0] ea, ec;
  logic [PB-1:0] eb, b_hold_pl;
  bit            b_hold = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic wait_drain(input int which, input int bound);
    int n = 0;
    while (qsize(which) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain_q%0d", which), qsize(which), 0);
  endtask

  // Monitors: compare every m_axis transfer against the model head.
  always @(negedge clk) begin
    if (!rst_a && a_m_valid && a_m_ready) begin
      if (a_out_cnt == 0) a_first_out = cyc;
      a_last_out = cyc;
      a_out_cnt++;
      check("a_expected_avail", qa.size() > 0, 1'b1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("a_beat", pa_now, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      b_hold = 1'b0;
    end else begin
      if (b_hold) begin
        check("b_valid_held", b_m_valid, 1'b1);
        check("b_payload_held", pb_now, b_hold_pl);
      end
      b_hold    = b_m_valid && !b_m_ready;
      b_hold_pl = pb_now;
      if (b_m_valid && b_m_ready) begin
        check("b_expected_avail", qb.size() > 0, 1'b1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          check("b_beat", pb_now, eb);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_c && c_m_valid && c_m_ready) begin
      check("c_expected_avail", qc.size() > 0, 1'b1);
      if (qc.size() > 0) begin
        ec = qc.pop_front();
        check("c_beat", pc_now, ec);
      end
    end
  end

  // Drivers: called at posedge+1, hold the beat until accepted, return at posedge+1.
  task automatic send_a(input logic [PA-1:0] pl);
    int n = 0;
    bit ok = 1'b0;
    {a_s_data, a_s_keep, a_s_user, a_s_last} = pl;
    a_s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (a_s_ready) begin
        qa.push_back(pl);
        if (a_in_cyc < 0) a_in_cyc = cyc;
        ok = 1'b1;
        break;
      end
      if (++n > 500) break;
      @(posedge clk); #1;
    end
    check("a_send_accepted", ok, 1'b1);
    @(posedge clk); #1;
    a_s_valid = 1'b0;
  endtask

  task automatic send_b(input logic [PB-1:0] pl);
    int n = 0;
    bit ok = 1'b0;
    {b_s_data, b_s_keep, b_s_user, b_s_last} = pl;
    b_s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (b_s_ready) begin
        qb.push_back(pl);
        ok = 1'b1;
        break;
      end
      if (++n > 500) break;
      @(posedge clk); #1;
    end
    if (!ok) check("b_send_accepted", ok, 1'b1);
    @(posedge clk); #1;
    b_s_valid = 1'b0;
  endtask

  task automatic send_c(input logic [PA-1:0] pl);
    int n = 0;
    bit ok = 1'b0;
    {c_s_data, c_s_keep, c_s_user, c_s_last} = pl;
    c_s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (c_s_ready) begin
        qc.push_back(pl);
        ok = 1'b1;
        break;
      end
      if (++n > 500) break;
      @(posedge clk); #1;
    end
    check("c_send_accepted", ok, 1'b1);
    @(posedge clk); #1;
    c_s_valid = 1'b0;
  endtask

  // 12 beats (3 packets of 4) with the sink stalled stall_len cycles after the first output.
  task automatic run_c(input int stall_len);
    logic [PA-1:0] hold;
    bit seen;
    c_m_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 12; i++)
          send_c({32'hC000_0000 + 32'(i), 4'(i), 1'b0, (i % 4) == 0});
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = c_m_valid;
        end
        check("c_first_valid_seen", seen, 1'b1);
        @(posedge clk); #1;
        c_m_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          check("c_valid_during_stall", c_m_valid, 1'b1);
          if (k == 0) hold = pc_now;
          else        check("c_data_stable", pc_now, hold);
        end
        check("c_s_ready_low_when_full", c_s_ready, 1'b0);
        @(posedge clk); #1;
        c_m_ready = 1'b1;
      end
    join
    wait_drain(2, 200);
    @(posedge clk); #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b_done;
    int k;
    {rst_a, rst_b, rst_c, rst_d} = 4'b1111;
    {a_s_valid, b_s_valid, c_s_valid, d_s_valid} = '0;
    {a_m_ready, b_m_ready, c_m_ready, d_m_ready} = 4'b1111;
    {a_s_data, a_s_keep, a_s_user, a_s_last} = '0;
    {b_s_data, b_s_keep, b_s_user, b_s_last} = '0;
    {c_s_data, c_s_keep, c_s_user, c_s_last} = '0;
    {d_s_data, d_s_keep, d_s_user, d_s_last} = '0;
    a_in_cyc = -1; a_out_cnt = 0; a_first_out = 0; a_last_out = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_s_ready", a_s_ready, 1'b0);
    check("a_rst_m_valid", a_m_valid, 1'b0);
    check("b_rst_m_valid", b_m_valid, 1'b0);
    check("c_rst_s_ready", c_s_ready, 1'b0);
    @(posedge clk); #1;
    {rst_a, rst_b, rst_c, rst_d} = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    check("a_ready_after_release", a_s_ready, 1'b1);
    check("c_ready_after_release", c_s_ready, 1'b1);
    @(posedge clk); #1;

    // A: 0x1..0x10 back-to-back, latency 2, no bubbles
    for (int i = 1; i <= 16; i++) send_a({32'(i), ~4'(i), 1'(i), i == 16});
    wait_drain(0, 50);
    @(posedge clk); #1;
    check("a_out_count", a_out_cnt, 16);
    check("a_latency", a_first_out - a_in_cyc, 2);
    check("a_no_bubbles", a_last_out - a_first_out, 15);

    // A: fill 4 beats, reset mid-flight, only the new beat emerges
    a_m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_a({32'h50 + 32'(i), 4'hF, 1'b0, 1'b0});
    @(negedge clk);
    check("a_full_s_ready", a_s_ready, 1'b0);
    check("a_full_m_valid", a_m_valid, 1'b1);
    @(posedge clk); #1;
    rst_a = 1'b1;
    qa.delete();
    @(posedge clk);
    @(negedge clk);
    check("a_midrst_m_valid", a_m_valid, 1'b0);
    check("a_midrst_s_ready", a_s_ready, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    a_m_ready = 1'b1;
    a_out_cnt = 0;
    send_a({32'hAA, 4'hF, 1'b1, 1'b1});
    wait_drain(0, 50);
    repeat (6) @(negedge clk);
    check("a_only_new_beat", a_out_cnt, 1);

    // D: STAGES=0 is a combinational pass-through
    for (int i = 0; i < 8; i++) begin
      d_s_valid = i[1];
      d_m_ready = i[0];
      d_s_data  = $urandom;
      d_s_keep  = 4'($urandom);
      d_s_user  = 1'($urandom);
      d_s_last  = 1'($urandom);
      #1;
      check("d_valid_through", d_m_valid, d_s_valid);
      check("d_payload_through", {d_m_data, d_m_keep, d_m_user, d_m_last},
            {d_s_data, d_s_keep, d_s_user, d_s_last});
      check("d_ready_through", d_s_ready, d_m_ready);
    end

    // C: 3-cycle stall, STAGES=1
    @(posedge clk); #1;
    run_c(3);

    // B: random valid (~50%) and ready (30%), 10000 beats
    b_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(1, 0) == 0) begin
            @(posedge clk); #1;
          end
          send_b({$urandom, $urandom, 8'($urandom), 1'($urandom), 1'($urandom)});
        end
        b_done = 1'b1;
      end
      begin
        k = 0;
        while (!b_done || (qb.size() != 0 && k < 5000)) begin
          if (b_done) k++;
          @(posedge clk); #1;
          b_m_ready = ($urandom_range(9, 0) < 3);
        end
      end
    join
    check("b_all_beats_out", qb.size(), 0);
    b_m_ready = 1'b1;

`ifdef AXIS_PIPE_SLICE_STAT_EN
    @(posedge clk); #1;
    rst_c = 1'b1;
    qc.delete();
    @(posedge clk); #1;
    rst_c = 1'b0;
    @(posedge clk); #1;
    run_c(5);
    repeat (2) @(posedge clk);
    #1;
    check("stat_beat_cnt", st_beat[2], 32'd12);
    check("stat_pkt_cnt", st_pkt[2], 32'd3);
    check("stat_stall_cnt", st_stall[2], 32'd5);
    force dut_c.beat_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_c.beat_cnt_q;
    @(posedge clk); #1;
    send_c({32'h5, 4'hF, 1'b0, 1'b1});
    wait_drain(2, 50);
    repeat (2) @(posedge clk);
    #1;
    check("stat_beat_wrap", st_beat[2], 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
